// File: rtl/tabby_bus_pkg.sv
// tabby_bus_pkg
//   Shared definitions for the external static-memory bus initiator:
//   bus-cycle state encoding, chip-select decode constants and the
//   fixed read-data values returned for unmapped and timed-out reads.
//   No ports; imported by tabby_ext_bus_master.
package tabby_bus_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_PULSE = 3'd2,
      ST_WAIT  = 3'd3,
      ST_HOLD  = 3'd4
   } bus_state_t;

   // avs_address[31:24] selector values and the matching active-low CSN
   localparam logic [7:0] CS0_SEL  = 8'h10;
   localparam logic [7:0] CS1_SEL  = 8'h20;
   localparam logic [7:0] CS2_SEL  = 8'h30;
   localparam logic [7:0] CS3_SEL  = 8'h40;
   localparam logic [3:0] CS0_CSN  = 4'b1110;
   localparam logic [3:0] CS1_CSN  = 4'b1101;
   localparam logic [3:0] CS2_CSN  = 4'b1011;
   localparam logic [3:0] CS3_CSN  = 4'b0111;
   localparam logic [3:0] CSN_NONE = 4'b1111;

   localparam logic [31:0] UNMAPPED_RDATA = 32'h0000_0000;
   localparam logic [31:0] TIMEOUT_RDATA  = 32'hFFFF_FFFF;

   // Returns {hit, csn}; hit=0 means the selector is unmapped.
   function automatic logic [4:0] cs_decode(input logic [7:0] sel);
      logic [4:0] res;
      case (sel)
         CS0_SEL: res = {1'b1, CS0_CSN};
         CS1_SEL: res = {1'b1, CS1_CSN};
         CS2_SEL: res = {1'b1, CS2_CSN};
         CS3_SEL: res = {1'b1, CS3_CSN};
         default: res = {1'b0, CSN_NONE};
      endcase
      return res;
   endfunction

endpackage

// File: rtl/tabby_sync2.sv
// tabby_sync2
//   Generic two-flop synchronizer for a single asynchronous input.
//   Ports:
//     q_clock   in   destination clock
//     q_reset   in   asynchronous, active-high; both flops load RESET_VAL
//     d_in      in   asynchronous input
//     q_out     out  synchronized output, two cycles of latency
module tabby_sync2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic q_clock,
   input  logic q_reset,
   input  logic d_in,
   output logic q_out
);

   logic meta;

   always_ff @(posedge q_clock or posedge q_reset) begin
      if (q_reset) begin
         meta  <= RESET_VAL;
         q_out <= RESET_VAL;
      end else begin
         meta  <= d_in;
         q_out <= meta;
      end
   end

endmodule

// File: rtl/tabby_ext_bus_master.sv
// tabby_ext_bus_master
//   Avalon-MM slave that runs one external asynchronous SRAM-style bus
//   cycle at a time: SETUP -> PULSE -> (WAIT) -> HOLD, with widths set by
//   SETUP_CYC / PULSE_CYC / HOLD_CYC and a WAITN stretch bounded by TIMEOUT.
//   Ports:
//     q_clock, q_reset          clock, asynchronous active-high reset
//     avs_address[31:0]         [31:24] chip select, [23:2] word address
//     avs_writedata, avs_byteenable, avs_read, avs_write   command
//     avs_readdata, avs_readdatavalid, avs_waitrequest     response
//     coe_ADDR[21:0]            external word address
//     coe_DATA_out/_in/_oe      split data bus, tristate lives at the pads
//     coe_CSN, coe_BEN          active-low chip selects / byte enables
//     coe_RDN, coe_WRN          active-low strobes
//     coe_WAITN                 active-low asynchronous wait from device
//     timeout_irq               one-cycle pulse when WAIT times out
module tabby_ext_bus_master
   import tabby_bus_pkg::*;
#(
   parameter int unsigned SETUP_CYC = 2,
   parameter int unsigned PULSE_CYC = 4,
   parameter int unsigned HOLD_CYC  = 2,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic        q_clock,
   input  logic        q_reset,
   input  logic [31:0] avs_address,
   input  logic [31:0] avs_writedata,
   input  logic [3:0]  avs_byteenable,
   input  logic        avs_read,
   input  logic        avs_write,
   output logic [31:0] avs_readdata,
   output logic        avs_readdatavalid,
   output logic        avs_waitrequest,
   output logic [21:0] coe_ADDR,
   output logic [31:0] coe_DATA_out,
   input  logic [31:0] coe_DATA_in,
   output logic        coe_DATA_oe,
   output logic [3:0]  coe_CSN,
   output logic [3:0]  coe_BEN,
   output logic        coe_RDN,
   output logic        coe_WRN,
   input  logic        coe_WAITN,
   output logic        timeout_irq
);

   localparam int unsigned CNT_W = 10;
   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT - 1);

   bus_state_t       state;
   logic [CNT_W-1:0] phase_cnt;   // down-counter for SETUP/PULSE/HOLD
   logic [CNT_W-1:0] ext_cnt;     // up-counter of WAIT cycles, saturating
   logic             is_rd;
   logic             waitn_s;

   logic [4:0]       cs_dec;
   logic             cs_hit;
   logic [3:0]       cs_csn;
   logic             strobe_done;
   logic             timed_out;
   logic             unused_addr_lsb;

   assign unused_addr_lsb = ^avs_address[1:0];

   tabby_sync2 #(.RESET_VAL(1'b1)) u_waitn_sync (
      .q_clock (q_clock),
      .q_reset (q_reset),
      .d_in    (coe_WAITN),
      .q_out   (waitn_s)
   );

   assign avs_waitrequest = (state != ST_IDLE);

   always_comb begin
      cs_dec      = cs_decode(avs_address[31:24]);
      cs_hit      = cs_dec[4];
      cs_csn      = cs_dec[3:0];
      timed_out   = (state == ST_WAIT) && !waitn_s && (ext_cnt == TO_LAST);
      strobe_done = ((state == ST_PULSE) && (phase_cnt == '0) && waitn_s) ||
                    ((state == ST_WAIT) && (waitn_s || timed_out));
   end

   always_ff @(posedge q_clock or posedge q_reset) begin
      if (q_reset) begin
         state             <= ST_IDLE;
         phase_cnt         <= '0;
         ext_cnt           <= '0;
         is_rd             <= 1'b0;
         coe_CSN           <= CSN_NONE;
         coe_BEN           <= '1;
         coe_RDN           <= 1'b1;
         coe_WRN           <= 1'b1;
         coe_DATA_oe       <= 1'b0;
         coe_ADDR          <= '0;
         coe_DATA_out      <= '0;
         avs_readdata      <= '0;
         avs_readdatavalid <= 1'b0;
         timeout_irq       <= 1'b0;
      end else begin
         avs_readdatavalid <= 1'b0;
         timeout_irq       <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (avs_read || avs_write) begin
                  if (!cs_hit) begin
                     // unmapped: reads complete immediately, writes vanish
                     if (avs_read) begin
                        avs_readdatavalid <= 1'b1;
                        avs_readdata      <= UNMAPPED_RDATA;
                     end
                  end else begin
                     state       <= ST_SETUP;
                     phase_cnt   <= SETUP_LAST;
                     is_rd       <= avs_read;
                     coe_CSN     <= cs_csn;
                     coe_ADDR    <= avs_address[23:2];
                     coe_BEN     <= ~avs_byteenable;
                     coe_DATA_oe <= !avs_read;
                     if (!avs_read) begin
                        coe_DATA_out <= avs_writedata;
                     end
                  end
               end
            end

            ST_SETUP: begin
               if (phase_cnt == '0) begin
                  state     <= ST_PULSE;
                  phase_cnt <= PULSE_LAST;
                  if (is_rd) begin
                     coe_RDN <= 1'b0;
                  end else begin
                     coe_WRN <= 1'b0;
                  end
               end else begin
                  phase_cnt <= phase_cnt - 1'b1;
               end
            end

            ST_PULSE: begin
               if (phase_cnt != '0) begin
                  phase_cnt <= phase_cnt - 1'b1;
               end else if (!waitn_s) begin
                  state   <= ST_WAIT;
                  ext_cnt <= '0;
               end
            end

            ST_WAIT: begin
               if (!strobe_done && (ext_cnt != '1)) begin
                  ext_cnt <= ext_cnt + 1'b1;
               end
            end

            ST_HOLD: begin
               if (phase_cnt == '0) begin
                  state       <= ST_IDLE;
                  coe_CSN     <= CSN_NONE;
                  coe_BEN     <= '1;
                  coe_DATA_oe <= 1'b0;
               end else begin
                  phase_cnt <= phase_cnt - 1'b1;
               end
            end

            default: state <= ST_IDLE;
         endcase

         // Strobe release is shared by the PULSE and WAIT exits, so it sits
         // after the case and overrides the state/counter written there.
         if (strobe_done) begin
            state       <= ST_HOLD;
            phase_cnt   <= HOLD_LAST;
            coe_RDN     <= 1'b1;
            coe_WRN     <= 1'b1;
            timeout_irq <= timed_out;
            if (is_rd) begin
               avs_readdatavalid <= 1'b1;
               avs_readdata      <= timed_out ? TIMEOUT_RDATA : coe_DATA_in;
            end
         end
      end
   end

endmodule

// File: doc/tabby_ext_bus_master.md
# tabby_ext_bus_master

Avalon-MM slave to external static-memory bus initiator: the outbound counterpart of the M1 host bridge. The host bridge lets the MCU drive the Qsys fabric. This block lets Qsys masters (Nios, DMA) drive an external asynchronous SRAM-style bus: 4 chip selects, 22-bit word address, 32-bit data, byte enables, RDN/WRN strobes and a WAITN stretch input. Setup, strobe and hold widths come from parameters. Bus cycles are serialized, one in flight.

## Interface
- SETUP_CYC, 2, cycles CSN/ADDR valid before strobe (≥1)
- PULSE_CYC, 4, minimum strobe-low cycles (≥3)
- HOLD_CYC, 2, cycles CSN/ADDR held after strobe release (≥1)
- TIMEOUT, 255, max extension cycles while WAITN low (1..1023)

- q_clock  in  1  block clock, 133.33 MHz MCLK domain
- q_reset  in  1  asynchronous, active-high
- avs_address  in  32  byte address; [31:24] chip select, [23:2] word address
- avs_writedata  in  32  write data
- avs_byteenable  in  4  active-high byte enables
- avs_read / avs_write  in  1  command strobes
- avs_readdata  out  32  registered read data
- avs_readdatavalid  out  1  one-cycle pulse
- avs_waitrequest  out  1  high while not IDLE
- coe_ADDR  out  22  external word address
- coe_DATA_out / coe_DATA_in  out/in  32  split data bus; pad tristate sits at top level
- coe_DATA_oe  out  1  data output enable
- coe_CSN  out  4  active-low chip selects
- coe_BEN  out  4  active-low byte enables
- coe_RDN / coe_WRN  out  1  active-low strobes
- coe_WAITN  in  1  active-low wait from device, asynchronous
- timeout_irq  out  1  one-cycle pulse on timeout

## Operation
- States: IDLE, SETUP, PULSE, WAIT, HOLD.
- IDLE: waitrequest=0. A command is accepted in any cycle where read or write is high.
  - On accept, latch address, data, byte enables and direction, then go to SETUP.
  - If read and write are both high, read wins and the write is dropped.
- CS decode on address[31:24]:
  - 0x10 → 1110, 0x20 → 1101, 0x30 → 1011, 0x40 → 0111.
  - Any other value is unmapped. Unmapped read: readdatavalid with 0x0000_0000 in the next cycle, no external activity. Unmapped write: dropped. Both return to IDLE.
- SETUP: CSN, ADDR and BEN driven. Write also sets DATA_oe=1. Lasts SETUP_CYC cycles, then PULSE.
- PULSE: RDN or WRN low for PULSE_CYC cycles.
  - Last cycle with synchronized WAITN=1: go to HOLD.
  - Last cycle with synchronized WAITN=0: go to WAIT.
- WAIT: strobe stays low. Exit to HOLD on the first cycle with synchronized WAITN=1.
- Timeout: WAIT lasting TIMEOUT cycles forces HOLD. Read returns 0xFFFF_FFFF. timeout_irq pulses for one cycle.
- Read data is captured from coe_DATA_in on the clock edge that leaves PULSE or WAIT.
- HOLD: strobe high; CSN, ADDR and DATA_oe unchanged.
  - avs_readdatavalid pulses in the first HOLD cycle (reads only).
  - After HOLD_CYC cycles, go to IDLE: CSN=1111, DATA_oe=0.
- WAITN passes through a 2-flop synchronizer, giving 2-cycle latency. The device must pull WAITN low within PULSE_CYC−2 cycles of the strobe falling.
- Reset, including mid-cycle: state=IDLE immediately. Output reset values:
  - CSN=1111, RDN=WRN=1, BEN=1111, DATA_oe=0, ADDR=0, DATA_out=0
  - readdata=0, readdatavalid=0, waitrequest=0, timeout_irq=0
  - A transaction in flight is lost; no readdatavalid is issued for it.

## Timing
- All coe_* outputs are registered and change only with state (no glitches).
- Cycle 0 is the accept cycle. SETUP occupies cycles 1..SETUP_CYC. PULSE occupies the next PULSE_CYC cycles, then WAIT extensions, then HOLD.
- Read latency, accept to readdatavalid: 1+SETUP_CYC+PULSE_CYC+ext cycles. Default with no extension: 7.
- Occupancy with no extension: 1+SETUP_CYC+PULSE_CYC+HOLD_CYC cycles. Default: 9. Next accept is possible in cycle 9.
- Extension and timeout counters are 10 bits wide and saturate.

## Structure
- Package tabby_bus_pkg holds:
  - the state enum
  - CS decode constants (0x10/0x20/0x30/0x40 and their CSN patterns)
  - UNMAPPED_RDATA=0 and TIMEOUT_RDATA=0xFFFF_FFFF
- Sub-module tabby_sync2: generic 2-flop synchronizer, reset value 1, used for WAITN.

## Test plan
- Read 0x1000_0010, WAITN=1, coe_DATA_in=0xA5A5_1234:
  - CSN=1110 and ADDR=0x000004 in cycles 1-8
  - RDN low in cycles 3-6
  - readdatavalid in cycle 7 with data 0xA5A5_1234
  - waitrequest low again in cycle 9
- Write 0x4000_0000, data 0xCAFE_F00D, byteenable=0011:
  - CSN=0111, BEN=1100, WRN low in cycles 3-6
  - DATA_oe=1 in cycles 1-8, DATA_out=0xCAFE_F00D
- Read with WAITN held low 10 cycles from cycle 3: RDN low through the extension, then readdatavalid carries the data present at WAITN release.
- WAITN stuck low: after 255 WAIT cycles, timeout_irq pulses once, readdata=0xFFFF_FFFF, then back to IDLE.
- Read 0x5000_0000: readdatavalid=1 with 0 in cycle 1, CSN stays 1111. Read and write asserted together: only the read is performed.
- q_reset asserted during PULSE: CSN=1111, RDN=1, DATA_oe=0 immediately; no readdatavalid follows.
